// File: rtl/div_share.sv
// Round-robin arbiter that shares one signed fixed-point divider among CH requesters.
// One division is in flight at a time; each response is tagged with the owning channel.
module div_share #(
  parameter  int WIDTH = 8,
  parameter  int FBITS = 4,
  parameter  int CH    = 4,
  localparam int CHW   = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       req,
  input  logic [CH*WIDTH-1:0] req_a,
  input  logic [CH*WIDTH-1:0] req_b,
  output logic [CH-1:0]       ack,
  output logic                rsp_valid,
  output logic [CHW-1:0]      rsp_id,
  output logic [WIDTH-1:0]    rsp_val,
  output logic                rsp_dbz,
  output logic                rsp_ovf,
  output logic                div_start,
  output logic [WIDTH-1:0]    div_a,
  output logic [WIDTH-1:0]    div_b,
  input  logic                div_done,
  input  logic                div_valid,
  input  logic                div_dbz,
  input  logic                div_ovf,
  input  logic [WIDTH-1:0]    div_val
);

  if (CH < 2 || CH > 16) begin : g_ch_check
    $error("div_share: CH must be in 2..16");
  end
  if (FBITS < 0 || FBITS >= WIDTH) begin : g_fbits_check
    $error("div_share: FBITS must be in 0..WIDTH-1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [CHW-1:0] ptr;
  logic [CHW-1:0] id;
  logic [CHW-1:0] win;
  logic           hit;

  // First requesting channel at or after ptr, wrapping CH-1 to 0.
  always_comb begin
    int             k;
    logic [CHW-1:0] idx;
    win = '0;
    hit = 1'b0;
    k   = 0;
    idx = '0;
    for (int i = 0; i < CH; i++) begin
      k = int'(ptr) + i;
      if (k >= CH) k = k - CH;
      idx = k[CHW-1:0];
      if (!hit && req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      ack       <= '0;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_val   <= '0;
      rsp_dbz   <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            id        <= win;
            div_a     <= req_a[win*WIDTH +: WIDTH];
            div_b     <= req_b[win*WIDTH +: WIDTH];
            ack       <= CH'(1) << win;
            div_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          ack       <= '0;
          div_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          // A rejected or overflowed result never leaks the divider's raw quotient.
          if (div_done) begin
            rsp_val   <= (div_valid && !div_dbz && !div_ovf) ? div_val : '0;
            rsp_dbz   <= div_dbz;
            rsp_ovf   <= div_ovf;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          ptr       <= (id == CHW'(CH - 1)) ? '0 : id + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share.sv
// Bench for div_share: a divider stub, a transaction-level scoreboard checked every
// cycle, and directed operations with hand-computed quotients, ordering and latencies.
module tb_div_share;
  localparam int WIDTH = 8;
  localparam int FBITS = 4;
  localparam int CH    = 4;
  localparam int CHW   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [CH-1:0]       req = '0;
  logic [CH*WIDTH-1:0] req_a = '0;
  logic [CH*WIDTH-1:0] req_b = '0;
  logic [CH-1:0]       ack;
  logic                rsp_valid;
  logic [CHW-1:0]      rsp_id;
  logic [WIDTH-1:0]    rsp_val;
  logic                rsp_dbz, rsp_ovf;
  logic                div_start;
  logic [WIDTH-1:0]    div_a, div_b;
  logic                div_done, div_valid, div_dbz, div_ovf;
  logic [WIDTH-1:0]    div_val;
  logic                stub_done;
  logic                stray = 1'b0;

  assign div_done = stub_done | stray;

  div_share #(.WIDTH(WIDTH), .FBITS(FBITS), .CH(CH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_val(rsp_val), .rsp_dbz(rsp_dbz),
    .rsp_ovf(rsp_ovf), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_valid(div_valid), .div_dbz(div_dbz), .div_ovf(div_ovf),
    .div_val(div_val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Divider stub: rejects b=0 or a most-negative operand on the next cycle,
  // otherwise answers after 3+b[1:0] cycles; garbage quotient when not valid.
  int cnt = 0;
  int q_s;
  always @(posedge clk) begin
    if (rst) begin
      stub_done <= 1'b0; div_valid <= 1'b0; div_dbz <= 1'b0; div_ovf <= 1'b0;
      div_val <= '0; cnt <= 0;
    end else begin
      stub_done <= 1'b0;
      if (div_start) begin
        if (div_b == 8'h00) begin
          stub_done <= 1'b1; div_dbz <= 1'b1; div_ovf <= 1'b0; div_valid <= 1'b0; div_val <= 8'hA5;
        end else if (div_a == 8'h80 || div_b == 8'h80) begin
          stub_done <= 1'b1; div_dbz <= 1'b0; div_ovf <= 1'b1; div_valid <= 1'b0; div_val <= 8'h5A;
        end else begin
          cnt <= 3 + int'(div_b[1:0]);
        end
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          q_s = (int'($signed(div_a)) * (1 << FBITS)) / int'($signed(div_b));
          stub_done <= 1'b1;
          div_dbz   <= 1'b0;
          if (q_s > 127 || q_s < -128) begin
            div_ovf <= 1'b1; div_valid <= 1'b0; div_val <= 8'hC3;
          end else begin
            div_ovf <= 1'b0; div_valid <= 1'b1; div_val <= q_s[7:0];
          end
        end
      end
    end
  end

  // Scoreboard state: scheduled ack / response cycles, held response fields.
  bit             armed = 0;
  bit             busy = 0;
  int             idle_from = 0, ack_cyc = -1, ack_ch = 0, rsp_cyc = -1, mptr = 0;
  logic [7:0]     ma = '0, mb = '0;
  int             e_id = 0, h_id = 0;
  logic [7:0]     e_val = '0, h_val = '0;
  bit             e_dbz = 0, e_ovf = 0, h_dbz = 0, h_ovf = 0;

  int         got_id[$];
  logic [7:0] got_val[$];
  bit         got_dbz[$];
  bit         got_ovf[$];
  int         got_cyc[$];
  int         ack_q_id[$];
  int         ack_q_cyc[$];

  always @(negedge clk) begin
    int            c, w;
    bit            f;
    logic [CH-1:0] eack;
    c = cyc;
    if (armed) begin
      eack = (c == ack_cyc) ? (CH'(1) << ack_ch) : '0;
      chk("ack", ack, eack);
      chk("div_start", div_start, c == ack_cyc);
      chk("div_a", div_a, ma);
      chk("div_b", div_b, mb);
      chk("rsp_valid", rsp_valid, c == rsp_cyc);
      if (c == rsp_cyc) begin
        h_id = e_id; h_val = e_val; h_dbz = e_dbz; h_ovf = e_ovf;
      end
      chk("rsp_id", rsp_id, h_id);
      chk("rsp_val", rsp_val, h_val);
      chk("rsp_dbz", rsp_dbz, h_dbz);
      chk("rsp_ovf", rsp_ovf, h_ovf);
      for (int i = 0; i < CH; i++)
        if (ack[i]) begin ack_q_id.push_back(i); ack_q_cyc.push_back(c); end
      if (rsp_valid) begin
        got_id.push_back(int'(rsp_id)); got_val.push_back(rsp_val);
        got_dbz.push_back(rsp_dbz); got_ovf.push_back(rsp_ovf); got_cyc.push_back(c);
      end
    end
    if (rst) begin
      armed = 1; busy = 0; ack_cyc = -1; rsp_cyc = -1; mptr = 0; idle_from = c + 1;
      ma = '0; mb = '0; h_id = 0; h_val = '0; h_dbz = 0; h_ovf = 0;
    end else if (armed) begin
      if (!busy && c >= idle_from && req != '0) begin
        f = 0; w = 0;
        for (int k = 0; k < CH; k++)
          if (!f && req[(mptr + k) % CH]) begin f = 1; w = (mptr + k) % CH; end
        ack_cyc = c + 1; ack_ch = w; busy = 1;
        ma = req_a[w*WIDTH +: WIDTH]; mb = req_b[w*WIDTH +: WIDTH];
      end else if (busy && c > ack_cyc && div_done) begin
        rsp_cyc = c + 1; busy = 0; idle_from = c + 2; mptr = (ack_ch + 1) % CH;
        e_id = ack_ch; e_dbz = div_dbz; e_ovf = div_ovf;
        e_val = (div_valid && !div_dbz && !div_ovf) ? div_val : 8'h00;
      end
    end
  end

  task automatic set_op(input int ch, input logic [7:0] a, input logic [7:0] b);
    req_a[ch*WIDTH +: WIDTH] = a;
    req_b[ch*WIDTH +: WIDTH] = b;
  endtask

  // Raise mask, drop each bit the cycle after its ack, wait for n responses.
  task automatic go(input logic [CH-1:0] mask, input int n, output int t0);
    int            base, k;
    logic [CH-1:0] drop;
    base = got_id.size();
    t0 = cyc;
    req = req | mask;
    k = 0;
    while (got_id.size() < base + n && k < 200) begin
      @(negedge clk); drop = ack;
      @(posedge clk); #1; req = req & ~drop;
      k++;
    end
    chk("resp_count", got_id.size(), base + n);
  endtask

  task automatic expect_rsp(input int idx, input int id, input logic [7:0] val,
                            input bit dbz, input bit ovf);
    if (idx < got_id.size()) begin
      chk("lit_id", got_id[idx], id);
      chk("lit_val", got_val[idx], val);
      chk("lit_dbz", got_dbz[idx], dbz);
      chk("lit_ovf", got_ovf[idx], ovf);
    end else begin
      chk("lit_present", got_id.size(), idx + 1);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_val", rsp_val, 0);
    chk("rst_div", {div_start, div_a, div_b}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, base, nack;
    req = '0;
    do_reset(3);

    // Single request: 3.0/2.0 = 1.5, then -3.0/2.0 = -1.5
    base = got_id.size();
    set_op(0, 8'h30, 8'h20);
    go(4'b0001, 1, t0);
    expect_rsp(base, 0, 8'h18, 0, 0);
    chk("ack_latency", ack_q_cyc[ack_q_cyc.size()-1] - t0, 1);
    set_op(0, 8'hD0, 8'h20);
    go(4'b0001, 1, t0);
    expect_rsp(base + 1, 0, 8'hE8, 0, 0);

    // All four at once after reset
    do_reset(2);
    base = got_id.size();
    set_op(0, 8'h30, 8'h20); set_op(1, 8'h10, 8'h40);
    set_op(2, 8'hE0, 8'h10); set_op(3, 8'h28, 8'hF0);
    go(4'b1111, 4, t0);
    expect_rsp(base,     0, 8'h18, 0, 0);
    expect_rsp(base + 1, 1, 8'h04, 0, 0);
    expect_rsp(base + 2, 2, 8'hE0, 0, 0);
    expect_rsp(base + 3, 3, 8'hD8, 0, 0);

    // Rotation: after channel 2, channel 3 wins over channel 0
    do_reset(2);
    base = got_id.size();
    set_op(2, 8'h20, 8'h20);
    go(4'b0100, 1, t0);
    expect_rsp(base, 2, 8'h10, 0, 0);
    set_op(0, 8'h40, 8'h20); set_op(3, 8'h08, 8'h10);
    go(4'b1001, 2, t0);
    expect_rsp(base + 1, 3, 8'h08, 0, 0);
    expect_rsp(base + 2, 0, 8'h20, 0, 0);

    // Divide by zero, response at T+3
    base = got_id.size();
    set_op(1, 8'h30, 8'h00);
    go(4'b0010, 1, t0);
    expect_rsp(base, 1, 8'h00, 1, 0);
    if (base < got_cyc.size()) chk("dbz_latency", got_cyc[base] - t0, 3);

    // Overflow: 7.0/0.5 and most-negative dividend
    set_op(0, 8'h70, 8'h08);
    go(4'b0001, 1, t0);
    expect_rsp(base + 1, 0, 8'h00, 0, 1);
    set_op(2, 8'h80, 8'h10);
    go(4'b0100, 1, t0);
    expect_rsp(base + 2, 2, 8'h00, 0, 1);
    if (base + 2 < got_cyc.size()) chk("ovf_latency", got_cyc[base + 2] - t0, 3);

    // Stray div_done while idle is ignored
    base = got_id.size();
    stray = 1'b1; @(posedge clk); #1 stray = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("stray_no_rsp", got_id.size(), base);

    // Reset during WAIT discards the operation
    base = got_id.size();
    nack = ack_q_id.size();
    set_op(1, 8'h30, 8'h30);
    req[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; req[1] = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("wait_rst_acks", ack_q_id.size(), nack + 1);
    chk("wait_rst_no_rsp", got_id.size(), base);
    chk("wait_rst_outs", {rsp_id, rsp_val, rsp_dbz, rsp_ovf, div_a, div_b}, 0);
    set_op(2, 8'h30, 8'h20);
    go(4'b0100, 1, t0);
    expect_rsp(base, 2, 8'h18, 0, 0);
    chk("post_rst_ack_latency", ack_q_cyc[ack_q_cyc.size()-1] - t0, 1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_share.md
# div_share

Round-robin arbiter that shares one signed fixed-point divider (`div`) among CH requesters. It sits between requesting engines (for example per-pixel or per-channel maths units) and a single divider instance. Each accepted request is issued to the divider, and the result is returned tagged with the requester's channel number. Only one division is in flight at a time.

## Interface

**Parameters**
- `WIDTH`, default 8: operand and result width in bits; passed through to the divider.
- `FBITS`, default 4: fractional bits; passed through to the divider.
- `CH`, default 4: number of requesters, 2..16.
- `CHW`: derived as $clog2(CH); not overridden.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `req`, in, CH: request per channel; held high until `ack`.
- `req_a`, in, CH*WIDTH: dividends; channel n occupies bits [n*WIDTH +: WIDTH].
- `req_b`, in, CH*WIDTH: divisors; same packing as `req_a`.
- `ack`, out, CH: one-hot, high for one cycle when that channel's request is accepted.
- `rsp_valid`, out, 1: response strobe, high for one cycle.
- `rsp_id`, out, CHW: channel that owns the response.
- `rsp_val`, out, WIDTH: quotient; 0 when `rsp_dbz` or `rsp_ovf` is set.
- `rsp_dbz`, out, 1: divide by zero.
- `rsp_ovf`, out, 1: overflow.
- `div_start`, out, 1: divider start.
- `div_a`, out, WIDTH: divider dividend.
- `div_b`, out, WIDTH: divider divisor.
- `div_done`, in, 1: divider done, one-cycle pulse.
- `div_valid`, in, 1: divider result valid.
- `div_dbz`, in, 1: divider divide-by-zero flag.
- `div_ovf`, in, 1: divider overflow flag.
- `div_val`, in, WIDTH: divider quotient.

## Operation

**Reset values**
- All outputs are 0, including `ack`, `rsp_*`, `div_start`, `div_a` and `div_b`.
- State is IDLE; round-robin pointer `ptr` is 0.

**States**
- IDLE:
  - If `req` is 0, stay in IDLE.
  - Otherwise pick winner w, the first set `req` bit scanning from `ptr` upward, wrapping CH-1 to 0.
  - Register `id`=w, `div_a`=req_a[w], `div_b`=req_b[w].
  - Go to ISSUE.
- ISSUE:
  - `ack[id]`=1 and `div_start`=1 for exactly this cycle.
  - Go to WAIT.
- WAIT:
  - Hold `div_a`/`div_b`.
  - On `div_done`, register `rsp_val` = (`div_valid` & !`div_dbz` & !`div_ovf`) ? `div_val` : 0.
  - Register `rsp_dbz`=`div_dbz`, `rsp_ovf`=`div_ovf`, `rsp_id`=`id`.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1 for this cycle.
  - `ptr` <= (`id`==CH-1) ? 0 : `id`+1.
  - Go to IDLE.

**Rules**
- `req` is sampled only in IDLE. A request dropped before `ack` is never served.
- The requester must drop `req` (or present a new operation) in the cycle after `ack`. A `req` still high in the next IDLE is treated as a new request.
- `div_done` outside WAIT is ignored.
- `rsp_val`/`rsp_dbz`/`rsp_ovf`/`rsp_id` hold their values after `rsp_valid` until the next response.
- Fairness: a continuously requesting channel waits at most CH-1 other operations.
- Reset mid-operation, in any state: immediate return to reset values. No `ack` or `rsp_valid` follows. The in-flight result is discarded, and the divider shares `rst`.
- A `div_done` arriving in the same cycle as `rst`: `rst` wins.

## Timing

- Request seen in IDLE at cycle T:
  - `ack` and `div_start` at T+1.
  - The divider samples start at the end of T+1.
- Divider rejects immediately (b=0 or operand = most negative value): `div_done` at T+2, `rsp_valid` at T+3.
- Normal division: `rsp_valid` is exactly one cycle after `div_done`.
- Back-to-back: next request is evaluated in IDLE at the cycle after `rsp_valid`. Per-operation overhead beyond the divider is 3 cycles.
- `rsp_valid` and `ack` are never high in the same cycle.

## Test plan

- **Single request:** WIDTH=8, FBITS=4. Channel 0, a=0x30 (3.0), b=0x20 (2.0) → `ack`=0001 at T+1; `rsp_valid` with `rsp_id`=0, `rsp_val`=0x18. Repeat with a=0xD0 → `rsp_val`=0xE8.
- **All channels at once after reset:** all four request simultaneously, each dropping `req` after its `ack` → responses in `rsp_id` order 0,1,2,3, each with its correct quotient.
- **Rotation:** after channel 2 is served, channels 0 and 3 request together → channel 3 is acked first, then 0.
- **Divide by zero:** channel 1 with b=0 → `rsp_valid` at T+3, `rsp_dbz`=1, `rsp_ovf`=0, `rsp_val`=0, `rsp_id`=1.
- **Overflow:** a=0x70 (7.0), b=0x08 (0.5) → `rsp_ovf`=1, `rsp_val`=0. A second case with a=0x80 → `rsp_ovf`=1 at T+3.
- **Reset in WAIT:** assert `rst` for one cycle during WAIT → no `rsp_valid` and all outputs 0. A following channel 2 request is served normally with `ptr` back at 0.
